vend_input_ctrl: RTL and testbench
==================================

Name: vend_input_ctrl

Overview:
Input front-end for the vending FSMs. It synchronizes and debounces the raw coin switch and select button, converts each press into a discrete event, and buffers events in a small FIFO. Events are released to the consuming FSM over a valid/ready handshake, so the FSM receives exactly one one-cycle m or a pulse per physical press. It sits between board switches/buttons and the moore/mealy machines, and runs on the prescaled clock.

Parameters:
DB_LIMIT, 4, consecutive stable cycles required to accept a level change (1..2^DB_CNT_W-1)
DB_CNT_W, 4, debounce counter width
FIFO_DEPTH, 4, event FIFO entries (power of 2, >=2)
CNT_W, 3, fifo_count width (must hold FIFO_DEPTH, i.e. log2(FIFO_DEPTH)+1)

Ports:
clk  in  1  clock (prescaled clock domain)
reset  in  1  synchronous, active-high reset
m_raw  in  1  raw coin switch, asynchronous, bouncy
a_raw  in  1  raw select button, asynchronous, bouncy
ev_ready  in  1  consumer can take an event this cycle
ev_valid  out  1  FIFO non-empty
m  out  1  one-cycle coin pulse to FSM
a  out  1  one-cycle select pulse to FSM
fifo_count  out  CNT_W  current FIFO occupancy
overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset, sampled on rising clk only: sync flops, debounced levels, debounce counters, FIFO pointers, count, pending flag, m, a and overflow all go to 0. ev_valid=0.
- Sync: each raw input passes through 2 flops. Debounce logic uses the second flop only.
- Debounce, per channel:
  - If sync level equals the debounced level, the counter clears.
  - Otherwise the counter increments. When it reaches DB_LIMIT, the debounced level takes the sync level and the counter clears.
  - A change therefore needs DB_LIMIT consecutive differing samples.
- Event generation: a 0->1 transition of a debounced level produces one event: COIN (code 0) or SEL (code 1). 1->0 transitions produce nothing.
- Push arbitration (one FIFO write per cycle):
  - COIN and SEL in the same cycle: COIN is written; SEL goes to a 1-entry pending register.
  - Pending SEL has priority on the next cycle.
  - A new SEL while pending is set is merged, not counted twice.
  - A COIN in the same cycle as a pending SEL is deferred to the next cycle through its own 1-entry pending flag.
- FIFO: circular buffer, 1-bit entries. ev_valid = (count != 0).
  - Pop occurs when ev_valid & ev_ready.
  - Push when not full: entry written, count+1.
  - Push when full without a pop in the same cycle: entry dropped, overflow <= 1, held until reset.
  - Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: push only, since no pop is possible.
  - Pointers wrap modulo FIFO_DEPTH.
- Output pulses are registered. A pop at edge N drives m=1 (head COIN) or a=1 (head SEL) during cycle N+1 only. m and a are never high together.
- Latency:
  - Press to FIFO entry: 2 sync cycles + DB_LIMIT cycles + 1 edge-detect cycle.
  - Entry to pulse: 1 cycle after the handshake.
- Reset mid-operation: all buffered and pending events are discarded, and any in-flight m/a pulse is forced to 0 the next cycle.

Optional Feature:
VEND_EVT_CNT_EN
- Defined: adds output ports coin_total[7:0] and sel_total[7:0]. They count popped COIN and SEL events, saturate at 255, and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Clean press: m_raw held 1 for 10 cycles, ev_ready=1 (DB_LIMIT=4) -> exactly one m pulse, 1 cycle wide, at cycle 8 after m_raw rises; a stays 0; fifo_count returns to 0.
- Bounce: m_raw toggles 1,0,1,0 on consecutive cycles then holds 1 -> a single m pulse; no pulse during toggling.
- Simultaneous: m_raw and a_raw rise in the same cycle, ev_ready=1 -> m pulse, then a pulse exactly one cycle later; COIN always first.
- Backpressure/overflow: ev_ready=0, 5 distinct coin presses (FIFO_DEPTH=4) -> fifo_count=4, overflow=1. Then ev_ready=1 -> exactly 4 m pulses on consecutive cycles, and overflow stays 1.
- Full + simultaneous push/pop: FIFO at 4, ev_ready=1 in the same cycle as a new SEL event -> count stays 4, overflow stays 0, and the SEL is delivered last.
- Reset mid-operation: 3 events buffered, reset pulsed for 1 cycle -> next cycle ev_valid=0, fifo_count=0, overflow=0, m=a=0. With VEND_EVT_CNT_EN: after 3 coin pops coin_total=3, then 0 after reset.

Source files
------------

// File: rtl/vend_input_ctrl.sv
// Switch/button front-end: 2-flop sync, counter debounce, rising-edge events, 1-bit event FIFO.
// Define VEND_EVT_CNT_EN to add saturating popped-event totals (coin_total, sel_total).
module vend_input_ctrl #(
    parameter int DB_LIMIT   = 4,
    parameter int DB_CNT_W   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m_raw,
    input  logic             a_raw,
    input  logic             ev_ready,
    output logic             ev_valid,
    output logic             m,
    output logic             a,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow
`ifdef VEND_EVT_CNT_EN
   ,output logic [7:0]       coin_total,
    output logic [7:0]       sel_total
`endif
);

    localparam int                  PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [DB_CNT_W-1:0] DB_LIM_C = DB_CNT_W'(DB_LIMIT);
    localparam logic [CNT_W-1:0]    DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic                EV_COIN  = 1'b0;
    localparam logic                EV_SEL   = 1'b1;

    // Channel index 0 is the coin switch, 1 is the select button.
    logic [1:0]                s1_q, s2_q, db_q, db_d, dbp_q, rise;
    logic [1:0][DB_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int c = 0; c < 2; c++) begin
            if (s2_q[c] == db_q[c]) begin
                cnt_d[c] = '0;
            end else if (cnt_q[c] + DB_CNT_W'(1) == DB_LIM_C) begin
                db_d[c]  = s2_q[c];
                cnt_d[c] = '0;
            end else begin
                cnt_d[c] = cnt_q[c] + DB_CNT_W'(1);
            end
        end
    end

    assign rise = db_q & ~dbp_q;

    // One write per cycle: pending SEL, then coin (pending or new), then new SEL.
    logic push, push_code, coin_any;
    logic coin_pend_q, coin_pend_d, sel_pend_q, sel_pend_d;

    always_comb begin
        coin_any    = rise[0] | coin_pend_q;
        push        = 1'b0;
        push_code   = EV_COIN;
        coin_pend_d = 1'b0;
        sel_pend_d  = 1'b0;
        if (sel_pend_q) begin
            push        = 1'b1;
            push_code   = EV_SEL;
            coin_pend_d = coin_any;
        end else if (coin_any) begin
            push       = 1'b1;
            push_code  = EV_COIN;
            sel_pend_d = rise[1];
        end else if (rise[1]) begin
            push      = 1'b1;
            push_code = EV_SEL;
        end
    end

    logic [FIFO_DEPTH-1:0] mem_q;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  full, pop, wr_en, head;
    logic                  m_q, a_q, ovf_q;

    assign ev_valid   = (count_q != '0);
    assign full       = (count_q == DEPTH_C);
    assign pop        = ev_valid & ev_ready;
    assign wr_en      = push & (~full | pop);
    assign head       = mem_q[rd_ptr_q];
    assign m          = m_q;
    assign a          = a_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_code;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q        <= '0;
            s2_q        <= '0;
            db_q        <= '0;
            dbp_q       <= '0;
            cnt_q       <= '0;
            coin_pend_q <= 1'b0;
            sel_pend_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            m_q         <= 1'b0;
            a_q         <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            s1_q        <= {a_raw, m_raw};
            s2_q        <= s1_q;
            db_q        <= db_d;
            dbp_q       <= db_q;
            cnt_q       <= cnt_d;
            coin_pend_q <= coin_pend_d;
            sel_pend_q  <= sel_pend_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (wr_en && !pop)      count_q <= count_q + CNT_W'(1);
            else if (!wr_en && pop) count_q <= count_q - CNT_W'(1);
            if (push && full && !pop) ovf_q <= 1'b1;
            m_q <= pop & (head == EV_COIN);
            a_q <= pop & (head == EV_SEL);
        end
    end

`ifdef VEND_EVT_CNT_EN
    logic [7:0] coin_tot_q, sel_tot_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            coin_tot_q <= '0;
            sel_tot_q  <= '0;
        end else if (pop) begin
            if (head == EV_COIN && coin_tot_q != 8'hFF) coin_tot_q <= coin_tot_q + 8'd1;
            if (head == EV_SEL  && sel_tot_q  != 8'hFF) sel_tot_q  <= sel_tot_q + 8'd1;
        end
    end

    assign coin_total = coin_tot_q;
    assign sel_total  = sel_tot_q;
`endif

endmodule

// File: tb/tb_vend_input_ctrl.sv
// Bench for vend_input_ctrl: directed scenarios plus random raw/ready/reset traffic against
// an event-queue reference model checked every cycle.
module tb_vend_input_ctrl;

    localparam int DBL   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0, reset = 1'b1, m_raw = 1'b0, a_raw = 1'b0, ev_ready = 1'b0;
    logic       ev_valid, m, a, overflow;
    logic [2:0] fifo_count;
`ifdef VEND_EVT_CNT_EN
    logic [7:0] coin_total, sel_total;
`endif

    vend_input_ctrl #(.DB_LIMIT(DBL), .DB_CNT_W(4), .FIFO_DEPTH(DEPTH), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .m_raw(m_raw), .a_raw(a_raw), .ev_ready(ev_ready),
        .ev_valid(ev_valid), .m(m), .a(a), .fifo_count(fifo_count), .overflow(overflow)
`ifdef VEND_EVT_CNT_EN
       ,.coin_total(coin_total), .sel_total(sel_total)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: sync history, debounce per channel, an age-ordered list of events
    // awaiting a FIFO slot (same-type newcomers merge), and the FIFO as a queue.
    int sy1[2], sy2[2], dbm[2], dbpm[2], cntm[2];
    int wq[$];
    int q[$];
    int em, ea, eovf, ecoin, esel;
    bit mdl_on = 1'b0;

    task automatic model_step(input bit rst, input bit r0, input bit r1, input bit rdy);
        int rs[2];
        int nw[$];
        int wcode;
        bit have, dup, popd;
        int hd;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                sy1[c] = 0; sy2[c] = 0; dbm[c] = 0; dbpm[c] = 0; cntm[c] = 0;
            end
            wq.delete(); q.delete();
            em = 0; ea = 0; eovf = 0; ecoin = 0; esel = 0;
            return;
        end
        for (int c = 0; c < 2; c++) rs[c] = (dbm[c] == 1 && dbpm[c] == 0) ? 1 : 0;
        nw = wq;
        for (int t = 0; t < 2; t++) begin
            if (rs[t] == 1) begin
                dup = 1'b0;
                foreach (wq[i]) if (wq[i] == t) dup = 1'b1;
                if (!dup) nw.push_back(t);
            end
        end
        have = (nw.size() > 0);
        wcode = 0;
        if (have) wcode = nw.pop_front();
        wq = nw;
        popd = (q.size() > 0) && rdy;
        hd = 0;
        if (popd) hd = q.pop_front();
        if (have) begin
            if (q.size() < DEPTH) q.push_back(wcode);
            else eovf = 1;
        end
        em = (popd && hd == 0) ? 1 : 0;
        ea = (popd && hd == 1) ? 1 : 0;
        if (em == 1 && ecoin < 255) ecoin++;
        if (ea == 1 && esel < 255) esel++;
        for (int c = 0; c < 2; c++) begin
            dbpm[c] = dbm[c];
            if (sy2[c] == dbm[c]) cntm[c] = 0;
            else begin
                cntm[c]++;
                if (cntm[c] == DBL) begin dbm[c] = sy2[c]; cntm[c] = 0; end
            end
            sy2[c] = sy1[c];
        end
        sy1[0] = r0;
        sy1[1] = r1;
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) model_step(reset, m_raw, a_raw, ev_ready);

    always @(negedge clk) begin
        if (mdl_on) begin
            chk("mdl_m", m, em);
            chk("mdl_a", a, ea);
            chk("mdl_count", fifo_count, q.size());
            chk("mdl_valid", ev_valid, (q.size() != 0) ? 1 : 0);
            chk("mdl_ovf", overflow, eovf);
`ifdef VEND_EVT_CNT_EN
            chk("mdl_coin_total", coin_total, ecoin);
            chk("mdl_sel_total", sel_total, esel);
`endif
        end
    end

    // Pulse log, read by the directed scenarios just after a rising edge.
    int m_cnt, a_cnt, both_cnt, m_first, m_last, a_first, a_last, last_ev;
    always @(negedge clk) begin
        if (m) begin m_cnt++; if (m_first < 0) m_first = cyc; m_last = cyc; last_ev = 0; end
        if (a) begin a_cnt++; if (a_first < 0) a_first = cyc; a_last = cyc; last_ev = 1; end
        if (m && a) both_cnt++;
    end

    task automatic clr_log();
        m_cnt = 0; a_cnt = 0; both_cnt = 0;
        m_first = -1; m_last = -1; a_first = -1; a_last = -1; last_ev = -1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_m(input int hold, input int low);
        m_raw = 1'b1; tick(hold);
        m_raw = 1'b0; tick(low);
    endtask

    int t0, hold_m, hold_a, rdy_pct;

    initial begin
        clr_log();
        tick(3);
        chk("rst_valid", ev_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_m", m, 0);
        chk("rst_a", a, 0);
        reset = 1'b0; mdl_on = 1'b1; ev_ready = 1'b1;
        tick(2);

        // clean coin press
        clr_log(); t0 = cyc;
        m_raw = 1'b1; tick(10); m_raw = 1'b0; tick(12);
        chk("clean_pulses", m_cnt, 1);
        chk("clean_latency", m_first - t0, 8);
        chk("clean_width", m_last - m_first, 0);
        chk("clean_no_a", a_cnt, 0);
        chk("clean_count", fifo_count, 0);

        // bouncing contact then a steady hold
        clr_log();
        m_raw = 1'b1; tick(1); m_raw = 1'b0; tick(1);
        m_raw = 1'b1; tick(1); m_raw = 1'b0; tick(1);
        t0 = cyc;
        m_raw = 1'b1; tick(10); m_raw = 1'b0; tick(12);
        chk("bounce_pulses", m_cnt, 1);
        chk("bounce_latency", m_first - t0, 8);

        // coin and select together: coin first, select one cycle later
        clr_log(); t0 = cyc;
        m_raw = 1'b1; a_raw = 1'b1; tick(10);
        m_raw = 1'b0; a_raw = 1'b0; tick(12);
        chk("simul_m", m_cnt, 1);
        chk("simul_a", a_cnt, 1);
        chk("simul_m_lat", m_first - t0, 8);
        chk("simul_a_after_m", a_first - m_first, 1);
        chk("simul_never_both", both_cnt, 0);

        // backpressure and overflow
        ev_ready = 1'b0; clr_log();
        repeat (5) press_m(6, 6);
        chk("bp_count", fifo_count, 4);
        chk("bp_ovf", overflow, 1);
        chk("bp_no_pulse", m_cnt, 0);
        t0 = cyc; ev_ready = 1'b1; tick(10);
        chk("drain_pulses", m_cnt, 4);
        chk("drain_first", m_first - t0, 1);
        chk("drain_consec", m_last - m_first, 3);
        chk("drain_ovf_sticky", overflow, 1);
        chk("drain_count", fifo_count, 0);

        // full FIFO: push and pop in the same cycle
        reset = 1'b1; tick(1); reset = 1'b0; tick(1);
        ev_ready = 1'b0; clr_log();
        repeat (4) press_m(6, 6);
        chk("full_count", fifo_count, 4);
        a_raw = 1'b1; tick(6);
        ev_ready = 1'b1; tick(1);
        chk("full_pushpop_count", fifo_count, 4);
        chk("full_pushpop_ovf", overflow, 0);
        a_raw = 1'b0; tick(12);
        chk("full_m_pulses", m_cnt, 4);
        chk("full_a_pulses", a_cnt, 1);
        chk("full_sel_last", last_ev, 1);

        // totals and reset in the middle of traffic
        reset = 1'b1; tick(1); reset = 1'b0; tick(1);
        ev_ready = 1'b1;
        repeat (3) press_m(6, 6);
        tick(4);
`ifdef VEND_EVT_CNT_EN
        chk("tot_coin3", coin_total, 3);
        chk("tot_sel0", sel_total, 0);
`endif
        ev_ready = 1'b0;
        repeat (3) press_m(6, 6);
        chk("mid_buffered", fifo_count, 3);
        reset = 1'b1; ev_ready = 1'b1; tick(1);
        reset = 1'b0;
        chk("mid_valid", ev_valid, 0);
        chk("mid_count", fifo_count, 0);
        chk("mid_ovf", overflow, 0);
        chk("mid_m", m, 0);
        chk("mid_a", a, 0);
`ifdef VEND_EVT_CNT_EN
        chk("mid_coin_total", coin_total, 0);
`endif
        tick(1);
        chk("mid_m_next", m, 0);

        // random traffic
        hold_m = 0; hold_a = 0;
        for (int seg = 0; seg < 6; seg++) begin
            rdy_pct = (seg % 3 == 0) ? 90 : ((seg % 3 == 1) ? 40 : 5);
            for (int i = 0; i < 500; i++) begin
                if (hold_m == 0) begin m_raw = ~m_raw; hold_m = $urandom_range(1, 12); end
                else hold_m--;
                if (hold_a == 0) begin a_raw = ~a_raw; hold_a = $urandom_range(1, 12); end
                else hold_a--;
                ev_ready = ($urandom_range(0, 99) < rdy_pct);
                reset = ($urandom_range(0, 399) == 0);
                tick(1);
            end
        end
        reset = 1'b0; ev_ready = 1'b1; m_raw = 1'b0; a_raw = 1'b0;
        tick(20);
        chk("end_drained", fifo_count, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
